// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters, with registered
// operands, a programmable ALU wait and a held response. Define ALU_ARB_STATS_EN for grant/conflict counters.
module alu_arbiter #(
  parameter int ALU_LATENCY = 1,
  parameter int DATA_W      = 32
) (
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt,
`endif
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_aluop,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_aluop,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_negative,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_port_A,
  output logic [DATA_W-1:0] alu_port_B,
  output logic [3:0]        alu_aluop,
  input  logic [DATA_W-1:0] alu_output_port,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY - 1);

  state_t     state;
  logic       rr;
  logic [3:0] lat_cnt;
  logic       op_id;
  logic       grant_any;
  logic       grant_id;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr;
    if (state == IDLE && !RST) begin
      if (rr ? req1_valid : req0_valid) begin
        grant_any = 1'b1;
        grant_id  = rr;
      end else if (rr ? req0_valid : req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~rr;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      rr           <= 1'b0;
      lat_cnt      <= '0;
      op_id        <= 1'b0;
      alu_port_A   <= '0;
      alu_port_B   <= '0;
      alu_aluop    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_negative <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are sampled only here; later request changes cannot reach the ALU.
          if (grant_any) begin
            op_id      <= grant_id;
            alu_aluop  <= grant_id ? req1_aluop : req0_aluop;
            alu_port_A <= grant_id ? req1_a     : req0_a;
            alu_port_B <= grant_id ? req1_b     : req0_b;
            lat_cnt    <= LAT_LOAD;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (lat_cnt == 4'd0) begin
            rsp_result   <= alu_output_port;
            rsp_negative <= alu_negative;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            rsp_id       <= op_id;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          // The requester just served loses priority; data fields stay for inspection.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr        <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (state == IDLE && req0_valid && req1_valid && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors with hand-computed responses,
// one instance at ALU_LATENCY=1 and one at ALU_LATENCY=3.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h7;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         neg;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_aluop, req1_aluop;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_negative, rsp_overflow, rsp_zero;
  logic [W-1:0] rsp_result, alu_port_A, alu_port_B, alu_output_port;
  logic [3:0] alu_aluop;
  logic alu_negative, alu_overflow, alu_zero;

  logic r3_valid, r3_ready, r3_unused_valid, r3_unused_ready;
  logic [3:0] r3_aluop;
  logic [W-1:0] r3_a, r3_b;
  logic rsp3_valid, rsp3_ready, rsp3_id, rsp3_negative, rsp3_overflow, rsp3_zero;
  logic [W-1:0] rsp3_result, alu3_port_A, alu3_port_B, alu3_output_port;
  logic [3:0] alu3_aluop;
  logic [W-1:0] tcnt = '0;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt, g3_0, g3_1, c3;
`endif

  alu_arbiter #(.ALU_LATENCY(1), .DATA_W(W)) u_dut (
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt),
`endif
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_negative(rsp_negative), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .alu_port_A(alu_port_A), .alu_port_B(alu_port_B), .alu_aluop(alu_aluop),
    .alu_output_port(alu_output_port), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  alu_arbiter #(.ALU_LATENCY(3), .DATA_W(W)) u_dut3 (
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(g3_0), .grant_cnt1(g3_1), .conflict_cnt(c3),
`endif
    .CLK(CLK), .RST(RST),
    .req0_valid(r3_valid), .req0_ready(r3_ready), .req0_aluop(r3_aluop),
    .req0_a(r3_a), .req0_b(r3_b),
    .req1_valid(r3_unused_valid), .req1_ready(r3_unused_ready), .req1_aluop(4'h0),
    .req1_a('0), .req1_b('0),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_id(rsp3_id), .rsp_result(rsp3_result),
    .rsp_negative(rsp3_negative), .rsp_overflow(rsp3_overflow), .rsp_zero(rsp3_zero),
    .alu_port_A(alu3_port_A), .alu_port_B(alu3_port_B), .alu_aluop(alu3_aluop),
    .alu_output_port(alu3_output_port), .alu_negative(alu3_output_port[W-1]),
    .alu_overflow(1'b0), .alu_zero(alu3_output_port == '0)
  );

  // Reference ALU for the latency-1 instance.
  logic [W-1:0] alu_r;
  always_comb begin
    alu_r        = alu_port_A & alu_port_B;
    alu_overflow = 1'b0;
    case (alu_aluop)
      OP_ADD: begin
        alu_r        = alu_port_A + alu_port_B;
        alu_overflow = (alu_port_A[W-1] == alu_port_B[W-1]) && (alu_r[W-1] != alu_port_A[W-1]);
      end
      OP_SUB: begin
        alu_r        = alu_port_A - alu_port_B;
        alu_overflow = (alu_port_A[W-1] != alu_port_B[W-1]) && (alu_r[W-1] != alu_port_A[W-1]);
      end
      default: ;
    endcase
    alu_output_port = alu_r;
    alu_negative    = alu_r[W-1];
    alu_zero        = (alu_r == '0);
  end

  // The latency-3 ALU output moves every cycle so the capture point is visible.
  always @(posedge CLK) tcnt <= tcnt + 1;
  assign alu3_output_port = tcnt ^ alu3_port_A;

  exp_t q0[$];
  exp_t q3[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [W-1:0] res,
                              input logic neg, input logic ovf, input logic zero);
    exp_t e;
    e.id = id; e.res = res; e.neg = neg; e.ovf = ovf; e.zero = zero;
    return e;
  endfunction

  initial begin : mon0
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge CLK); #2;
      if (rsp_valid && !seen) begin
        check("rsp0_expected", q0.size() != 0, 1'b1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("rsp0_id", rsp_id, e.id);
          check("rsp0_result", rsp_result, e.res);
          check("rsp0_negative", rsp_negative, e.neg);
          check("rsp0_overflow", rsp_overflow, e.ovf);
          check("rsp0_zero", rsp_zero, e.zero);
        end
      end
      seen = rsp_valid;
    end
  end

  initial begin : mon3
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge CLK); #2;
      if (rsp3_valid && !seen) begin
        check("rsp3_expected", q3.size() != 0, 1'b1);
        if (q3.size() != 0) begin
          e = q3.pop_front();
          check("rsp3_id", rsp3_id, e.id);
          check("rsp3_result", rsp3_result, e.res);
          check("rsp3_negative", rsp3_negative, e.neg);
          check("rsp3_zero", rsp3_zero, e.zero);
        end
      end
      seen = rsp3_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_ready(input logic rid);
    int n = 0;
    #1;
    while (!(rid ? req1_ready : req0_ready) && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    check("ready_timeout", n < 50, 1'b1);
  endtask

  task automatic issue(input logic rid, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    @(negedge CLK);
    q0.push_back(e);
    if (rid) begin req1_valid = 1'b1; req1_aluop = op; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_aluop = op; req0_a = a; req0_b = b; end
    wait_ready(rid);
    @(negedge CLK);
    // Scramble the request fields after acceptance; they must not reach the ALU.
    if (rid) begin req1_valid = 1'b0; req1_a = 32'hDEADBEEF; req1_b = 32'hDEADBEEF; end
    else     begin req0_valid = 1'b0; req0_a = 32'hDEADBEEF; req0_b = 32'hDEADBEEF; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge CLK); #3; n++;
    end
    check("drain_timeout", n < 100, 1'b1);
  endtask

  initial begin : stim
    int n;
    logic [W-1:0] t_acc;
    RST = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_aluop = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_aluop = '0; req1_a = '0; req1_b = '0;
    r3_valid = 1'b0; r3_unused_valid = 1'b0; r3_aluop = '0; r3_a = '0; r3_b = '0;
    rsp3_ready = 1'b1;

    // Reset state; a valid during reset must not be granted.
    @(negedge CLK); @(negedge CLK);
    req0_valid = 1'b1;
    #1;
    check("reset_no_ready", req0_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_result", rsp_result, '0);
    check("reset_alu_a", alu_port_A, '0);
    check("reset_alu_op", alu_aluop, '0);
    req0_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Single op, latency 1: 5 + 7 = 12.
    @(negedge CLK);
    q0.push_back(mk(1'b0, 32'd12, 1'b0, 1'b0, 1'b0));
    req0_valid = 1'b1; req0_aluop = OP_ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    @(negedge CLK); #1;
    check("single_ready_one_cycle", req0_ready, 1'b0);
    check("single_exec_no_rsp", rsp_valid, 1'b0);
    check("single_alu_op", alu_aluop, OP_ADD);
    check("single_alu_a", alu_port_A, 32'd5);
    check("single_alu_b", alu_port_B, 32'd7);
    req0_valid = 1'b0; req0_a = 32'hDEADBEEF;
    @(negedge CLK); #1;
    check("single_rsp_timing", rsp_valid, 1'b1);
    @(negedge CLK); #1;
    check("single_rsp_done", rsp_valid, 1'b0);
    // Back in IDLE with rr=1: req1 granted immediately. 5 - 5 = 0.
    q0.push_back(mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b1));
    req1_valid = 1'b1; req1_aluop = OP_SUB; req1_a = 32'd5; req1_b = 32'd5;
    #1;
    check("idle_after_rsp_ready1", req1_ready, 1'b1);
    @(negedge CLK);
    req1_valid = 1'b0;
    issue(1'b0, OP_ADD, 32'h7FFFFFFF, 32'd1, mk(1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0));
    issue(1'b1, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, mk(1'b1, 32'h00F000F0, 1'b0, 1'b0, 1'b0));
    drain();

    // Contention from reset: grants alternate 0,1,0,1, one every 3 cycles.
    do_reset();
    req0_valid = 1'b1; req0_aluop = OP_ADD; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1'b1; req1_aluop = OP_ADD; req1_a = 32'd10; req1_b = 32'd20;
    q0.push_back(mk(1'b0, 32'd3,  1'b0, 1'b0, 1'b0));
    q0.push_back(mk(1'b1, 32'd30, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(1'b0, 32'd3,  1'b0, 1'b0, 1'b0));
    q0.push_back(mk(1'b1, 32'd30, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      check($sformatf("contend_ready0_c%0d", i), req0_ready, (i % 3 == 0) && ((i / 3) % 2 == 0));
      check($sformatf("contend_ready1_c%0d", i), req1_ready, (i % 3 == 0) && ((i / 3) % 2 == 1));
    end
    @(negedge CLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Backpressure: 0 - 1 = FFFFFFFF, negative set; response held 5 cycles.
    @(negedge CLK);
    rsp_ready = 1'b0;
    issue(1'b0, OP_SUB, 32'd0, 32'd1, mk(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    q0.push_back(mk(1'b1, 32'd7, 1'b0, 1'b0, 1'b0));
    req1_valid = 1'b1; req1_aluop = OP_ADD; req1_a = 32'd3; req1_b = 32'd4;
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin @(negedge CLK); #1; n++; end
    check("bp_rsp_timeout", n < 20, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", rsp_valid, 1'b1);
      check("bp_result_held", rsp_result, 32'hFFFFFFFF);
      check("bp_negative_held", rsp_negative, 1'b1);
      check("bp_no_ready", req1_ready, 1'b0);
      @(negedge CLK); #1;
    end
    rsp_ready = 1'b1;
    @(negedge CLK); #1;
    check("bp_ready_after_handshake", req1_ready, 1'b1);
    @(negedge CLK);
    req1_valid = 1'b0;
    drain();

    // Reset mid-op: leave rr=1, start a req1 op, reset in EXEC.
    issue(1'b0, OP_ADD, 32'd2, 32'd2, mk(1'b0, 32'd4, 1'b0, 1'b0, 1'b0));
    drain();
    @(negedge CLK);
    req1_valid = 1'b1; req1_aluop = OP_SUB; req1_a = 32'd9; req1_b = 32'd4;
    #1;
    check("rst_mid_ready1", req1_ready, 1'b1);
    @(negedge CLK);
    req1_valid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    req0_valid = 1'b1; req0_aluop = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_rsp_result", rsp_result, '0);
    check("rst_mid_alu_a", alu_port_A, '0);
    check("rst_mid_alu_b", alu_port_B, '0);
    check("rst_mid_alu_op", alu_aluop, '0);
    check("rst_mid_no_ready", req0_ready, 1'b0);
    RST = 1'b0;
    q0.push_back(mk(1'b0, 32'd2, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(1'b1, 32'd4, 1'b0, 1'b0, 1'b0));
    req1_valid = 1'b1; req1_aluop = OP_ADD; req1_a = 32'd2; req1_b = 32'd2;
    #1;
    check("rst_rr_ready0", req0_ready, 1'b1);
    check("rst_rr_ready1", req1_ready, 1'b0);
    @(negedge CLK);
    req0_valid = 1'b0;
    wait_ready(1'b1);
    @(negedge CLK);
    req1_valid = 1'b0;
    drain();

    // Stats scenario: three req0-only ops, then two contended ops (req1 first since rr=1).
    do_reset();
    issue(1'b0, OP_ADD, 32'd1, 32'd1, mk(1'b0, 32'd2, 1'b0, 1'b0, 1'b0));
    issue(1'b0, OP_ADD, 32'd2, 32'd1, mk(1'b0, 32'd3, 1'b0, 1'b0, 1'b0));
    issue(1'b0, OP_ADD, 32'd3, 32'd1, mk(1'b0, 32'd4, 1'b0, 1'b0, 1'b0));
    drain();
    @(negedge CLK);
    q0.push_back(mk(1'b1, 32'd14, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(1'b0, 32'd12, 1'b0, 1'b0, 1'b0));
    req0_valid = 1'b1; req0_aluop = OP_ADD; req0_a = 32'd6; req0_b = 32'd6;
    req1_valid = 1'b1; req1_aluop = OP_ADD; req1_a = 32'd7; req1_b = 32'd7;
    #1;
    check("stats_ready1_first", req1_ready, 1'b1);
    check("stats_ready0_waits", req0_ready, 1'b0);
    @(negedge CLK);
    wait_ready(1'b0);
    @(negedge CLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
`ifdef ALU_ARB_STATS_EN
    check("stats_grant_cnt0", grant_cnt0, 16'd4);
    check("stats_grant_cnt1", grant_cnt1, 16'd1);
    check("stats_conflict_cnt", conflict_cnt, 16'd2);
`endif

    // Latency 3: value captured 3 cycles after accept, rsp_valid 4 cycles after accept.
    @(negedge CLK);
    r3_valid = 1'b1; r3_aluop = OP_ADD; r3_a = 32'h10000000; r3_b = 32'd0;
    #1;
    check("lat3_ready", r3_ready, 1'b1);
    t_acc = tcnt;
    q3.push_back(mk(1'b0, (t_acc + 32'd3) ^ 32'h10000000, 1'b0, 1'b0, 1'b0));
    @(negedge CLK);
    r3_valid = 1'b0; r3_a = 32'hDEADBEEF;
    n = 1;
    #1;
    while (!rsp3_valid && n < 20) begin @(negedge CLK); #1; n++; end
    check("lat3_cycles", n, 4);
    n = 0;
    while (q3.size() != 0 && n < 20) begin @(negedge CLK); #3; n++; end

    drain();
    check("q0_leftover", q0.size(), 0);
    check("q3_leftover", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
